// File: rtl/decode_regfile_if.sv
// Decode/register-file bus: instruction and write-back controls in,
// decoded fields, operands and $ra view out.
interface decode_regfile_if #(
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned INST_W = 32;
  localparam int unsigned AW     = 5;

  logic [INST_W-1:0] Inst;
  logic              RegWrite;
  logic [1:0]        RegDst;
  logic              ExtOp;
  logic [DATA_W-1:0] WriteData;
  logic [5:0]        Opcode;
  logic [5:0]        Funct;
  logic [4:0]        Shamt;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic [DATA_W-1:0] ExtImm;
  logic [AW-1:0]     WriteReg;
  logic [DATA_W-1:0] reg31;

  modport master (
    output Inst, RegWrite, RegDst, ExtOp, WriteData,
    input  Opcode, Funct, Shamt, ReadData1, ReadData2, ExtImm, WriteReg, reg31
  );

  modport slave (
    input  Inst, RegWrite, RegDst, ExtOp, WriteData,
    output Opcode, Funct, Shamt, ReadData1, ReadData2, ExtImm, WriteReg, reg31
  );
endinterface

// File: rtl/decode_regfile.sv
// Instruction decode and 32-entry register file with synchronous write-back,
// combinational reads and a direct $ra view for the fetch stage.
module decode_regfile #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned LINK_REG = 31
) (
  input  logic             Clock,
  input  logic             Reset,
  decode_regfile_if.slave  bus
);
  localparam int unsigned AW    = 5;
  localparam int unsigned IMM_W = 16;

  logic [DATA_W-1:0] regs [NREGS];
  logic [AW-1:0]     rs;
  logic [AW-1:0]     rt;
  logic [AW-1:0]     rd;
  logic [AW-1:0]     wr_idx;
  logic [IMM_W-1:0]  imm;

  assign rs  = bus.Inst[25:21];
  assign rt  = bus.Inst[20:16];
  assign rd  = bus.Inst[15:11];
  assign imm = bus.Inst[15:0];

  assign bus.Opcode = bus.Inst[31:26];
  assign bus.Shamt  = bus.Inst[10:6];
  assign bus.Funct  = bus.Inst[5:0];

  // Destination select; the reserved encoding falls back to rt.
  always_comb begin
    wr_idx = rt;
    case (bus.RegDst)
      2'b01:   wr_idx = rd;
      2'b10:   wr_idx = AW'(LINK_REG);
      default: wr_idx = rt;
    endcase
  end

  assign bus.WriteReg = wr_idx;

  assign bus.ExtImm = bus.ExtOp ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm}
                                : {{(DATA_W-IMM_W){1'b0}}, imm};

  // Reset wins over write-back; index 0 is never stored.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.RegWrite && (wr_idx != '0)) begin
      regs[wr_idx] <= bus.WriteData;
    end
  end

  // No bypass: reads see the pre-edge contents.
  assign bus.ReadData1 = (rs == '0) ? '0 : regs[rs];
  assign bus.ReadData2 = (rt == '0) ? '0 : regs[rt];
  assign bus.reg31     = regs[AW'(LINK_REG)];
endmodule

// File: tb/tb_decode_regfile.sv
// Directed bench for decode_regfile: reset, write-back, $zero, immediates,
// link/$ra, read-during-write and reset priority.
module tb_decode_regfile;
  logic Clock;
  logic Reset;
  int   checks;
  int   failures;

  decode_regfile_if #(.DATA_W(32)) bus ();

  decode_regfile #(.DATA_W(32), .NREGS(32), .LINK_REG(31)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd,
                                     input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  // Advance past the next rising edge, leaving time to settle.
  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic idle();
    bus.RegWrite  = 1'b0;
    bus.RegDst    = 2'b00;
    bus.ExtOp     = 1'b0;
    bus.WriteData = '0;
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] val);
    bus.Inst      = mk(6'h00, 5'd0, 5'd0, rd, 5'd0, 6'h20);
    bus.RegDst    = 2'b01;
    bus.RegWrite  = 1'b1;
    bus.WriteData = val;
    tick();
    idle();
  endtask

  task automatic test_reset();
    wr(5'd5, 32'hDEADBEEF);
    wr(5'd31, 32'h0000ABCD);
    bus.Inst = mk(6'h00, 5'd5, 5'd0, 5'd0, 5'd0, 6'h00);
    #1;
    checks++;
    if (bus.ReadData1 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL reset_prewrite got=%h exp=%h", bus.ReadData1, 32'hDEADBEEF);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
    checks++;
    if (bus.ReadData1 !== 32'h0) begin
      failures++;
      $display("FAIL reset_r5 got=%h exp=%h", bus.ReadData1, 32'h0);
    end
    checks++;
    if (bus.reg31 !== 32'h0) begin
      failures++;
      $display("FAIL reset_reg31 got=%h exp=%h", bus.reg31, 32'h0);
    end
  endtask

  task automatic test_rtype();
    bus.Inst      = 32'h00A62020;
    bus.RegDst    = 2'b01;
    bus.RegWrite  = 1'b1;
    bus.WriteData = 32'h12345678;
    #1;
    checks++;
    if (bus.WriteReg !== 5'd4) begin
      failures++;
      $display("FAIL rtype_writereg got=%0d exp=%0d", bus.WriteReg, 4);
    end
    checks++;
    if (bus.Opcode !== 6'h00 || bus.Funct !== 6'h20) begin
      failures++;
      $display("FAIL rtype_fields got=%h/%h exp=00/20", bus.Opcode, bus.Funct);
    end
    tick();
    idle();
    bus.Inst = mk(6'h00, 5'd4, 5'd0, 5'd0, 5'd0, 6'h00);
    #1;
    checks++;
    if (bus.ReadData1 !== 32'h12345678) begin
      failures++;
      $display("FAIL rtype_readback got=%h exp=%h", bus.ReadData1, 32'h12345678);
    end
  endtask

  task automatic test_zero();
    bus.Inst      = mk(6'h08, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00);
    bus.RegDst    = 2'b00;
    bus.RegWrite  = 1'b1;
    bus.WriteData = 32'hFFFFFFFF;
    #1;
    checks++;
    if (bus.WriteReg !== 5'd0) begin
      failures++;
      $display("FAIL zero_writereg got=%0d exp=%0d", bus.WriteReg, 0);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.ReadData2 !== 32'h0 || bus.ReadData1 !== 32'h0) begin
      failures++;
      $display("FAIL zero_read got=%h/%h exp=0/0", bus.ReadData1, bus.ReadData2);
    end
  endtask

  task automatic test_writereg_mux();
    logic [4:0] exp_idx [4];
    exp_idx[0] = 5'd9; exp_idx[1] = 5'd17; exp_idx[2] = 5'd31; exp_idx[3] = 5'd9;
    bus.Inst = mk(6'h00, 5'd1, 5'd9, 5'd17, 5'd0, 6'h00);
    for (int i = 0; i < 4; i++) begin
      bus.RegDst = 2'(i);
      #1;
      checks++;
      if (bus.WriteReg !== exp_idx[i]) begin
        failures++;
        $display("FAIL regdst_%0d got=%0d exp=%0d", i, bus.WriteReg, exp_idx[i]);
      end
    end
    bus.RegDst = 2'b00;
  endtask

  task automatic test_imm();
    bus.Inst  = 32'h20008003;
    bus.ExtOp = 1'b1;
    #1;
    checks++;
    if (bus.ExtImm !== 32'hFFFF8003) begin
      failures++;
      $display("FAIL imm_sext got=%h exp=%h", bus.ExtImm, 32'hFFFF8003);
    end
    bus.ExtOp = 1'b0;
    #1;
    checks++;
    if (bus.ExtImm !== 32'h00008003) begin
      failures++;
      $display("FAIL imm_zext got=%h exp=%h", bus.ExtImm, 32'h00008003);
    end
    bus.Inst  = 32'h20007FFF;
    bus.ExtOp = 1'b1;
    #1;
    checks++;
    if (bus.ExtImm !== 32'h00007FFF) begin
      failures++;
      $display("FAIL imm_sext_pos got=%h exp=%h", bus.ExtImm, 32'h00007FFF);
    end
    bus.ExtOp = 1'b0;
  endtask

  task automatic test_fields();
    bus.Inst = mk(6'h23, 5'd1, 5'd2, 5'd3, 5'd17, 6'h2A);
    #1;
    checks++;
    if (bus.Opcode !== 6'h23 || bus.Shamt !== 5'd17 || bus.Funct !== 6'h2A) begin
      failures++;
      $display("FAIL fields got=%h/%h/%h exp=23/11/2a", bus.Opcode, bus.Shamt, bus.Funct);
    end
  endtask

  task automatic test_link();
    bus.Inst      = mk(6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00);
    bus.RegDst    = 2'b10;
    bus.RegWrite  = 1'b1;
    bus.WriteData = 32'h0000000D;
    #1;
    checks++;
    if (bus.WriteReg !== 5'd31) begin
      failures++;
      $display("FAIL link_writereg got=%0d exp=%0d", bus.WriteReg, 31);
    end
    checks++;
    if (bus.reg31 !== 32'h0) begin
      failures++;
      $display("FAIL link_before got=%h exp=%h", bus.reg31, 32'h0);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.reg31 !== 32'h0000000D) begin
      failures++;
      $display("FAIL link_after got=%h exp=%h", bus.reg31, 32'hD);
    end
    wr(5'd31, 32'h00000055);
    #1;
    checks++;
    if (bus.reg31 !== 32'h00000055) begin
      failures++;
      $display("FAIL reg31_rd got=%h exp=%h", bus.reg31, 32'h55);
    end
  endtask

  task automatic test_back_to_back();
    wr(5'd7, 32'h1);
    bus.Inst      = mk(6'h00, 5'd7, 5'd7, 5'd0, 5'd0, 6'h00);
    bus.RegDst    = 2'b00;
    bus.RegWrite  = 1'b1;
    bus.WriteData = 32'h2;
    #1;
    checks++;
    if (bus.ReadData1 !== 32'h1 || bus.ReadData2 !== 32'h1) begin
      failures++;
      $display("FAIL rdw_before got=%h/%h exp=1/1", bus.ReadData1, bus.ReadData2);
    end
    tick();
    #1;
    checks++;
    if (bus.ReadData1 !== 32'h2) begin
      failures++;
      $display("FAIL rdw_after got=%h exp=%h", bus.ReadData1, 32'h2);
    end
    idle();
    wr(5'd7, 32'h1);
    bus.Inst      = mk(6'h00, 5'd7, 5'd7, 5'd0, 5'd0, 6'h00);
    bus.RegDst    = 2'b00;
    bus.RegWrite  = 1'b1;
    bus.WriteData = 32'h2;
    Reset         = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
    checks++;
    if (bus.ReadData1 !== 32'h0) begin
      failures++;
      $display("FAIL reset_priority got=%h exp=%h", bus.ReadData1, 32'h0);
    end
    bus.WriteData = 32'h3;
    tick();
    idle();
    #1;
    checks++;
    if (bus.ReadData1 !== 32'h3) begin
      failures++;
      $display("FAIL reset_resume got=%h exp=%h", bus.ReadData1, 32'h3);
    end
  endtask

  task automatic test_x_inst();
    bus.RegWrite = 1'b0;
    bus.Inst     = 'x;
    tick();
    tick();
    bus.Inst = mk(6'h00, 5'd7, 5'd0, 5'd0, 5'd0, 6'h00);
    #1;
    checks++;
    if (bus.ReadData1 !== 32'h3) begin
      failures++;
      $display("FAIL x_inst_hold got=%h exp=%h", bus.ReadData1, 32'h3);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Reset    = 1'b1;
    bus.Inst = '0;
    idle();
    tick();
    tick();
    Reset = 1'b0;
    test_reset();
    test_rtype();
    test_zero();
    test_writereg_mux();
    test_imm();
    test_fields();
    test_link();
    test_back_to_back();
    test_x_inst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
